phyreg_alloc_ctrl: RTL and testbench
====================================

Name: phyreg_alloc_ctrl

Overview:
- Allocation controller between the 2-wide rename stage and the physical-register freelist.
- Keeps a credit count of free physical registers and grants freelist pops per rename slot, all-or-nothing per group.
- Sequences flush recovery: holds allocation off for a fixed number of cycles while the freelist rebuilds, then restores full credit.

Parameters:
- FREE_REG, 32, number of allocatable physical registers (freelist depth).
- RECOVER_CYCLES, 2, cycles allocation stays blocked after a flush (>=1).
- CNT_W, $clog2(FREE_REG)+1, width of the credit counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush / mispredict recovery request.
- req0_valid  in  1  rename slot 0 holds an instruction.
- req0_need_rd  in  1  slot 0 writes a non-zero rd and needs a new physical register.
- req1_valid  in  1  rename slot 1 holds an instruction.
- req1_need_rd  in  1  slot 1 needs a new physical register.
- retire_valid  in  1  commit returns one old physical register to the freelist.
- grant0  out  1  pop the freelist for slot 0 (drives freelist slot-0 valid).
- grant1  out  1  pop the freelist for slot 1.
- rename_ready  out  1  rename group accepted this cycle.
- stall  out  1  valid group present but not accepted.
- free_cnt  out  CNT_W  current credit count.
- almost_empty  out  1  free_cnt < 2.
- recovering  out  1  FSM in RECOVER.
- credit_err  out  1  sticky: retire arrived with free_cnt == FREE_REG.

Behaviour:
- Reset (rst_n low, asynchronous): state=ALLOC, free_cnt=FREE_REG, recover counter=0, credit_err=0. Combinational outputs then resolve to grant0=grant1=0, rename_ready=1 (no requests), stall=0, recovering=0.
- Demand: need0 = req0_valid & req0_need_rd; need1 = req1_valid & req1_need_rd; need = need0 + need1 (0..2). Requests with valid=1 and need_rd=0 consume no credit.
- ALLOC state, all combinational from the registered free_cnt:
  - need <= free_cnt: grant0=need0, grant1=need1, rename_ready=1, stall=0.
  - otherwise: grant0=grant1=0, rename_ready=0, stall=(req0_valid|req1_valid). No partial grant: slot 0 is never granted alone when the pair does not fit.
- Credit update in ALLOC: free_cnt_next = free_cnt - (grant0+grant1) + retire_valid.
  - A retire credit is not usable for a grant in the same cycle.
  - Retire when free_cnt==FREE_REG: free_cnt holds (no increment), credit_err set, and remains set until reset.
  - free_cnt never underflows, since grants are bounded by free_cnt.
- flush=1 in any state, highest priority: next state=RECOVER, recover counter=RECOVER_CYCLES-1. Grants are forced 0 in the flush cycle. rename_ready=0 and stall=0 in the flush cycle. free_cnt holds.
- RECOVER state:
  - grant0=grant1=0, rename_ready=0, stall=0, recovering=1. retire_valid ignored (the freelist rebuild covers it).
  - Each cycle the counter decrements. When the counter==0 and flush=0: free_cnt<=FREE_REG, state<=ALLOC.
  - Allocation resumes on the next cycle.
  - Flush during RECOVER reloads the counter (restart).
- Latency: flush at cycle T gives first possible grant at T+RECOVER_CYCLES+1.
- Reset mid-RECOVER returns immediately to ALLOC with full credit.
- almost_empty is derived from the registered free_cnt.

Test Plan:
- Reset, then req0/req1 valid+need for 16 cycles -> grant0=grant1=1 every cycle; free_cnt 32→0; on the 17th cycle stall=1, grants 0.
- free_cnt=1 with both slots needing rd -> no grant, stall=1. Then slot1 need_rd=0 -> grant0=1, grant1=0, free_cnt 1→0.
- free_cnt=0 with retire_valid and a pair request -> no grant this cycle; free_cnt=1 next cycle; single-need request then granted.
- Flush at T with RECOVER_CYCLES=2 -> recovering=1 at T+1 and T+2; free_cnt=32 and grants possible at T+3. Second flush at T+1 -> ALLOC delayed to T+4.
- Retire at free_cnt=32 -> free_cnt stays 32; credit_err=1 and sticky until rst_n.
- rst_n asserted low mid-RECOVER -> outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/phyreg_alloc_ctrl.sv
// phyreg_alloc_ctrl
//   Credit-based allocation controller between a 2-wide rename stage and the
//   physical-register freelist. Tracks free registers, grants freelist pops
//   per rename slot on an all-or-nothing basis per group, and sequences flush
//   recovery (allocation blocked for RECOVER_CYCLES, then full credit).
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               flush / mispredict recovery request
//   req{0,1}_valid      rename slot holds an instruction
//   req{0,1}_need_rd    slot needs a new physical register
//   retire_valid        commit returns one physical register
//   grant{0,1}          freelist pop for slot 0/1
//   rename_ready        rename group accepted this cycle
//   stall               valid group present but not accepted
//   free_cnt            current credit count
//   almost_empty        free_cnt < 2
//   recovering          FSM in RECOVER
//   credit_err          sticky: retire arrived with full credit
module phyreg_alloc_ctrl #(
    parameter int FREE_REG       = 32,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = $clog2(FREE_REG) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req0_valid,
    input  logic             req0_need_rd,
    input  logic             req1_valid,
    input  logic             req1_need_rd,
    input  logic             retire_valid,
    output logic             grant0,
    output logic             grant1,
    output logic             rename_ready,
    output logic             stall,
    output logic [CNT_W-1:0] free_cnt,
    output logic             almost_empty,
    output logic             recovering,
    output logic             credit_err
);

    localparam int NUM_SLOTS = 2;
    localparam int RC_W      = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    typedef enum logic {ALLOC, RECOVER} state_t;

    state_t                 state;
    logic [RC_W-1:0]        rcnt;
    logic [NUM_SLOTS-1:0]   req_valid;
    logic [NUM_SLOTS-1:0]   req_need;
    logic [NUM_SLOTS-1:0]   need_vec;
    logic [NUM_SLOTS-1:0]   grant_vec;
    logic [1:0]             need_cnt;
    logic [CNT_W-1:0]       grant_cnt;
    logic                   alloc_ok;
    logic                   fits;

    assign req_valid = {req1_valid, req0_valid};
    assign req_need  = {req1_need_rd, req0_need_rd};

    // Per-slot demand and grant; a slot only gets a pop when the whole group fits.
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign need_vec[i]  = req_valid[i] & req_need[i];
        assign grant_vec[i] = alloc_ok & fits & need_vec[i];
    end

    assign need_cnt  = {1'b0, need_vec[0]} + {1'b0, need_vec[1]};
    assign grant_cnt = CNT_W'(grant_vec[0]) + CNT_W'(grant_vec[1]);

    // Decisions use the registered credit only; a same-cycle retire is not spendable.
    assign fits     = CNT_W'(need_cnt) <= free_cnt;
    assign alloc_ok = (state == ALLOC) & ~flush;

    assign grant0       = grant_vec[0];
    assign grant1       = grant_vec[1];
    assign rename_ready = alloc_ok & fits;
    assign stall        = alloc_ok & ~fits & (|req_valid);
    assign almost_empty = free_cnt < CNT_W'(2);
    assign recovering   = (state == RECOVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ALLOC;
            free_cnt   <= CNT_W'(FREE_REG);
            rcnt       <= '0;
            credit_err <= 1'b0;
        end else if (flush) begin
            // Flush wins in any state; credit holds until the rebuild completes.
            state <= RECOVER;
            rcnt  <= RC_W'(RECOVER_CYCLES - 1);
        end else begin
            case (state)
                ALLOC: begin
                    if (retire_valid && free_cnt == CNT_W'(FREE_REG)) begin
                        // Surplus retire: drop the increment and flag it.
                        free_cnt   <= free_cnt - grant_cnt;
                        credit_err <= 1'b1;
                    end else begin
                        free_cnt <= free_cnt - grant_cnt + CNT_W'(retire_valid);
                    end
                end
                RECOVER: begin
                    // Retires are ignored here; the rebuilt freelist is full.
                    if (rcnt == '0) begin
                        free_cnt <= CNT_W'(FREE_REG);
                        state    <= ALLOC;
                    end else begin
                        rcnt <= rcnt - 1'b1;
                    end
                end
                default: state <= ALLOC;
            endcase
        end
    end

endmodule

// File: tb/tb_phyreg_alloc_ctrl.sv
module tb_phyreg_alloc_ctrl;

    localparam int CNT_W = 6;

    typedef struct {
        string      name;
        logic       g0, g1, rr, st;
        logic [5:0] fc;
        logic       ae, rc, ce;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic req0_valid = 1'b0, req0_need_rd = 1'b0;
    logic req1_valid = 1'b0, req1_need_rd = 1'b0;
    logic retire_valid = 1'b0;
    logic grant0, grant1, rename_ready, stall, almost_empty, recovering, credit_err;
    logic [CNT_W-1:0] free_cnt;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    phyreg_alloc_ctrl #(.FREE_REG(32), .RECOVER_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_need_rd(req0_need_rd),
        .req1_valid(req1_valid), .req1_need_rd(req1_need_rd),
        .retire_valid(retire_valid),
        .grant0(grant0), .grant1(grant1), .rename_ready(rename_ready), .stall(stall),
        .free_cnt(free_cnt), .almost_empty(almost_empty),
        .recovering(recovering), .credit_err(credit_err)
    );

    task automatic compare(input exp_t e);
        total++;
        if ({grant0, grant1, rename_ready, stall, free_cnt, almost_empty, recovering, credit_err} !==
            {e.g0, e.g1, e.rr, e.st, e.fc, e.ae, e.rc, e.ce}) begin
            bad++;
            $display("FAIL %s: got g0=%b g1=%b rr=%b st=%b fc=%0d ae=%b rc=%b ce=%b, want g0=%b g1=%b rr=%b st=%b fc=%0d ae=%b rc=%b ce=%b",
                     e.name, grant0, grant1, rename_ready, stall, free_cnt, almost_empty, recovering, credit_err,
                     e.g0, e.g1, e.rr, e.st, e.fc, e.ae, e.rc, e.ce);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) compare(sb.pop_front());
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic cyc(input string nm,
                       input logic v0, n0, v1, n1, ret, fl,
                       input logic g0, g1, rr, st, input int fc,
                       input logic ae, rc, ce);
        exp_t e;
        @(posedge clk); #1;
        req0_valid = v0; req0_need_rd = n0;
        req1_valid = v1; req1_need_rd = n1;
        retire_valid = ret; flush = fl;
        e.name = nm; e.g0 = g0; e.g1 = g1; e.rr = rr; e.st = st;
        e.fc = 6'(fc); e.ae = ae; e.rc = rc; e.ce = ce;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        #12 rst_n = 1'b1;
        //   name          v0 n0 v1 n1 rt fl   g0 g1 rr st fc  ae rc ce
        cyc("reset",       0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 32, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            cyc("pair_grant", 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 32 - 2 * i, 0, 0, 0);
        cyc("empty_stall", 1, 1, 1, 1, 0, 0,   0, 0, 0, 1, 0,  1, 0, 0);
        cyc("retire_nouse",1, 1, 1, 1, 1, 0,   0, 0, 0, 1, 0,  1, 0, 0);
        cyc("one_pair",    1, 1, 1, 1, 0, 0,   0, 0, 0, 1, 1,  1, 0, 0);
        cyc("one_single",  1, 1, 1, 0, 0, 0,   1, 0, 1, 0, 1,  1, 0, 0);
        cyc("idle_zero",   0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0,  1, 0, 0);
        cyc("ret_single",  1, 1, 0, 0, 1, 0,   0, 0, 0, 1, 0,  1, 0, 0);
        cyc("single_gnt",  1, 1, 0, 0, 0, 0,   1, 0, 1, 0, 1,  1, 0, 0);
        cyc("no_rd_zero",  1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0,  1, 0, 0);
        // flush at T, RECOVER_CYCLES=2
        cyc("flush_T",     1, 1, 1, 1, 0, 1,   0, 0, 0, 0, 0,  1, 0, 0);
        cyc("rec_T1",      1, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0,  1, 1, 0);
        cyc("rec_T2",      1, 1, 1, 1, 1, 0,   0, 0, 0, 0, 0,  1, 1, 0);
        cyc("resume_T3",   1, 1, 1, 1, 0, 0,   1, 1, 1, 0, 32, 0, 0, 0);
        cyc("after_T4",    0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 30, 0, 0, 0);
        // back-to-back flush delays resume to T+4
        cyc("flush2_T",    1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 30, 0, 0, 0);
        cyc("flush2_T1",   1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 30, 0, 1, 0);
        cyc("flush2_T2",   1, 1, 1, 1, 0, 0,   0, 0, 0, 0, 30, 0, 1, 0);
        cyc("flush2_T3",   1, 1, 1, 1, 0, 0,   0, 0, 0, 0, 30, 0, 1, 0);
        cyc("flush2_T4",   1, 1, 1, 1, 0, 0,   1, 1, 1, 0, 32, 0, 0, 0);
        // climb back to full, then a surplus retire
        cyc("ret_30",      0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 30, 0, 0, 0);
        cyc("ret_31",      0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 31, 0, 0, 0);
        cyc("ret_full",    0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 32, 0, 0, 0);
        cyc("err_set",     0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 32, 0, 0, 1);
        cyc("err_sticky",  1, 1, 1, 1, 0, 0,   1, 1, 1, 0, 32, 0, 0, 1);
        cyc("err_flush",   0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 30, 0, 0, 1);
        cyc("err_rec",     0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 30, 0, 1, 1);
        // reset asserted mid-RECOVER, checked before any clock edge
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        e.name = "async_reset"; e.g0 = 0; e.g1 = 0; e.rr = 1; e.st = 0;
        e.fc = 6'd32; e.ae = 0; e.rc = 0; e.ce = 0;
        compare(e);
        @(posedge clk); #2 rst_n = 1'b1;
        cyc("post_reset",  1, 1, 1, 1, 0, 0,   1, 1, 1, 0, 32, 0, 0, 0);
        cyc("post_idle",   0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 30, 0, 0, 0);
        // drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
